// File: rtl/debug_halt_ctrl.sv
// Debug halt sequencer: drains the pipeline, holds the core halted, and
// forwards PC-override, GPR-write and single-step requests to the control unit.
module debug_halt_ctrl #(
  parameter int DRAIN_TIMEOUT = 64,
  parameter int ADDR_WIDTH    = 64,
  parameter int XLEN          = 64
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  halt_req_i,
  input  logic                  resume_req_i,
  input  logic                  step_req_i,
  input  logic                  change_pc_req_i,
  input  logic [ADDR_WIDTH-1:0] change_pc_addr_i,
  input  logic                  reg_wr_req_i,
  input  logic [4:0]            reg_wr_addr_i,
  input  logic [XLEN-1:0]       reg_wr_data_i,
  input  logic                  pipeline_empty_i,
  input  logic                  fetch_fire_i,
  input  logic                  commit_valid_i,
  output logic                  fetch_stall_o,
  output logic                  debug_halt_o,
  output logic                  debug_change_pc_o,
  output logic [ADDR_WIDTH-1:0] debug_pc_o,
  output logic                  debug_wr_valid_o,
  output logic [4:0]            debug_wr_addr_o,
  output logic [XLEN-1:0]       debug_wr_data_o,
  output logic                  req_ack_o,
  output logic                  halted_o,
  output logic                  drain_err_o
);

  localparam int CNT_W_MIN = $clog2(DRAIN_TIMEOUT) + 1;
  localparam int CNT_W     = (CNT_W_MIN > 7) ? CNT_W_MIN : 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {RUNNING, DRAINING, HALTED, STEPPING} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  step_fetched_q, step_fetched_d;
  logic                  drain_err_q, drain_err_d;
  logic                  change_pc_q, change_pc_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;

  logic timeout;
  logic acc_change_pc, acc_reg_wr, acc_step, acc_resume;

  assign timeout = (cnt_q == CNT_LAST);

  // Fixed priority: change_pc > reg_wr > step > resume, only while halted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    acc_change_pc = 1'b0;
    acc_reg_wr    = 1'b0;
    acc_step      = 1'b0;
    acc_resume    = 1'b0;
    if (state_q == HALTED) begin
      acc_change_pc = change_pc_req_i;
      acc_reg_wr    = reg_wr_req_i & ~change_pc_req_i;
      acc_step      = step_req_i & ~change_pc_req_i & ~reg_wr_req_i;
      acc_resume    = resume_req_i & ~change_pc_req_i & ~reg_wr_req_i & ~step_req_i;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    step_fetched_d = 1'b0;
    drain_err_d    = drain_err_q;
    change_pc_d    = acc_change_pc;
    wr_valid_d     = acc_reg_wr & (reg_wr_addr_i != 5'd0);
    pc_d           = acc_change_pc ? change_pc_addr_i : pc_q;
    wr_addr_d      = acc_reg_wr ? reg_wr_addr_i : wr_addr_q;
    wr_data_d      = acc_reg_wr ? reg_wr_data_i : wr_data_q;

    case (state_q)
      RUNNING: begin
        if (halt_req_i) state_d = DRAINING;
      end
      DRAINING: begin
        if (pipeline_empty_i) begin
          state_d = HALTED;
        end else if (timeout) begin
          state_d     = HALTED;
          drain_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HALTED: begin
        if (acc_step) begin
          state_d = STEPPING;
        end else if (acc_resume) begin
          state_d     = RUNNING;
          drain_err_d = 1'b0;
        end
      end
      STEPPING: begin
        step_fetched_d = step_fetched_q | fetch_fire_i;
        // A commit in the timeout cycle wins, so no error is flagged then.
        if (commit_valid_i) begin
          state_d = DRAINING;
        end else if (timeout) begin
          state_d     = DRAINING;
          drain_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RUNNING;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rstn_i) begin
      state_q        <= RUNNING;
      cnt_q          <= '0;
      step_fetched_q <= 1'b0;
      drain_err_q    <= 1'b0;
      change_pc_q    <= 1'b0;
      wr_valid_q     <= 1'b0;
      pc_q           <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      step_fetched_q <= step_fetched_d;
      drain_err_q    <= drain_err_d;
      change_pc_q    <= change_pc_d;
      wr_valid_q     <= wr_valid_d;
      pc_q           <= pc_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign fetch_stall_o     = (state_q == DRAINING) || (state_q == HALTED) ||
                             ((state_q == STEPPING) && step_fetched_q);
  assign debug_halt_o      = (state_q == HALTED);
  assign halted_o          = (state_q == HALTED);
  assign req_ack_o         = acc_change_pc | acc_reg_wr | acc_step | acc_resume;
  assign debug_change_pc_o = change_pc_q;
  assign debug_pc_o        = pc_q;
  assign debug_wr_valid_o  = wr_valid_q;
  assign debug_wr_addr_o   = wr_addr_q;
  assign debug_wr_data_o   = wr_data_q;
  assign drain_err_o       = drain_err_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Self-checking bench for debug_halt_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a behavioural model.
module tb_debug_halt_ctrl;

  localparam int DT = 8;
  localparam logic [63:0] CPC_ADDR = 64'h0000_0000_8000_1000;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_STEP = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        halt_req, resume_req, step_req, cpc_req, wr_req;
  logic [63:0] cpc_addr;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        empty, fire, commit;
  logic        fetch_stall, dbg_halt, dbg_cpc, dbg_wrv, req_ack, halted, drain_err;
  logic [63:0] dbg_pc, dbg_wr_data;
  logic [4:0]  dbg_wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, cycles spent in the current mode, pending pulses.
  int          m_mode, m_wait;
  bit          m_fetched, m_err, m_cpc, m_wrv;
  logic [63:0] m_pc, m_data;
  logic [4:0]  m_addr;

  debug_halt_ctrl #(.DRAIN_TIMEOUT(DT), .ADDR_WIDTH(64), .XLEN(64)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .halt_req_i(halt_req), .resume_req_i(resume_req), .step_req_i(step_req),
    .change_pc_req_i(cpc_req), .change_pc_addr_i(cpc_addr),
    .reg_wr_req_i(wr_req), .reg_wr_addr_i(wr_addr), .reg_wr_data_i(wr_data),
    .pipeline_empty_i(empty), .fetch_fire_i(fire), .commit_valid_i(commit),
    .fetch_stall_o(fetch_stall), .debug_halt_o(dbg_halt),
    .debug_change_pc_o(dbg_cpc), .debug_pc_o(dbg_pc),
    .debug_wr_valid_o(dbg_wrv), .debug_wr_addr_o(dbg_wr_addr),
    .debug_wr_data_o(dbg_wr_data), .req_ack_o(req_ack), .halted_o(halted),
    .drain_err_o(drain_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_wait = 0; m_fetched = 0; m_err = 0;
    m_cpc = 0; m_wrv = 0; m_pc = '0; m_data = '0; m_addr = '0;
  endtask

  task automatic model_compare();
    bit busy;
    busy = cpc_req | wr_req | step_req | resume_req;
    check("m_stall",  fetch_stall, 64'((m_mode == M_DRAIN) || (m_mode == M_HALT) ||
                                       ((m_mode == M_STEP) && m_fetched)));
    check("m_halt",   dbg_halt,    64'(m_mode == M_HALT));
    check("m_halted", halted,      64'(m_mode == M_HALT));
    check("m_ack",    req_ack,     64'((m_mode == M_HALT) && busy));
    check("m_cpc",    dbg_cpc,     64'(m_cpc));
    check("m_pc",     dbg_pc,      m_pc);
    check("m_wrv",    dbg_wrv,     64'(m_wrv));
    check("m_waddr",  dbg_wr_addr, 64'(m_addr));
    check("m_wdata",  dbg_wr_data, m_data);
    check("m_err",    drain_err,   64'(m_err));
  endtask

  // One clock of the model, using the inputs present at the edge.
  task automatic model_update();
    int nm;
    bool_timeout: begin end
    if (!rstn) begin
      model_reset();
      return;
    end
    nm = m_mode;
    m_cpc = 0;
    m_wrv = 0;
    case (m_mode)
      M_RUN:   if (halt_req) nm = M_DRAIN;
      M_DRAIN: if (empty) nm = M_HALT;
               else if (m_wait == DT - 1) begin nm = M_HALT; m_err = 1; end
      M_HALT:  if (cpc_req) begin m_pc = cpc_addr; m_cpc = 1; end
               else if (wr_req) begin m_addr = wr_addr; m_data = wr_data; m_wrv = (wr_addr != 0); end
               else if (step_req) begin nm = M_STEP; m_fetched = 0; end
               else if (resume_req) begin nm = M_RUN; m_err = 0; end
      default: begin
        if (fire) m_fetched = 1;
        if (commit) nm = M_DRAIN;
        else if (m_wait == DT - 1) begin nm = M_DRAIN; m_err = 1; end
      end
    endcase
    m_wait = (nm == m_mode) ? m_wait + 1 : 0;
    m_mode = nm;
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_compare();
  endtask

  task automatic to_next();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    halt_req = 0; resume_req = 0; step_req = 0; cpc_req = 0; wr_req = 0;
    cpc_addr = CPC_ADDR; wr_addr = '0; wr_data = '0;
    empty = 1; fire = 0; commit = 0;
  endtask

  task automatic cycle();
    at_neg();
    to_next();
  endtask

  // Empty pipeline: halt pulse, one DRAINING cycle, then halted.
  task automatic go_halted();
    empty = 1; halt_req = 1; cycle();
    halt_req = 0; cycle();
  endtask

  typedef struct {
    bit          halt, resume, step, cpc, wr;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    bit          empty;
    bit          e_stall, e_halted, e_ack, e_cpc, e_wrv, e_err;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int drained;
    tbl[0]  = '{0,0,0,0,0, 5'd0, 64'h0,      1, 0,0,0,0,0,0, 5'd0, 64'h0};
    tbl[1]  = '{1,0,0,0,0, 5'd0, 64'h0,      1, 0,0,0,0,0,0, 5'd0, 64'h0};
    tbl[2]  = '{0,0,0,0,0, 5'd0, 64'h0,      1, 1,0,0,0,0,0, 5'd0, 64'h0};
    tbl[3]  = '{0,0,0,0,0, 5'd0, 64'h0,      1, 1,1,0,0,0,0, 5'd0, 64'h0};
    tbl[4]  = '{0,0,0,1,1, 5'd5, 64'hDEAD,   1, 1,1,1,0,0,0, 5'd0, 64'h0};
    tbl[5]  = '{0,0,0,0,1, 5'd5, 64'hDEAD,   1, 1,1,1,1,0,0, 5'd0, 64'h0};
    tbl[6]  = '{0,0,0,0,0, 5'd0, 64'h0,      1, 1,1,0,0,1,0, 5'd5, 64'hDEAD};
    tbl[7]  = '{0,0,0,0,1, 5'd0, 64'h1234,   1, 1,1,1,0,0,0, 5'd0, 64'h0};
    tbl[8]  = '{0,0,0,0,0, 5'd0, 64'h0,      1, 1,1,0,0,0,0, 5'd0, 64'h0};
    tbl[9]  = '{0,1,0,0,0, 5'd0, 64'h0,      1, 1,1,1,0,0,0, 5'd0, 64'h0};
    tbl[10] = '{0,0,0,0,0, 5'd0, 64'h0,      1, 0,0,0,0,0,0, 5'd0, 64'h0};

    idle_inputs();
    rstn = 0;
    repeat (2) to_next();
    rstn = 1;

    // Directed table: halt latency, change_pc + reg_wr priority, x0 write, resume.
    for (int i = 0; i < 11; i++) begin
      halt_req = tbl[i].halt; resume_req = tbl[i].resume; step_req = tbl[i].step;
      cpc_req = tbl[i].cpc; wr_req = tbl[i].wr; wr_addr = tbl[i].waddr;
      wr_data = tbl[i].wdata; empty = tbl[i].empty;
      at_neg();
      check($sformatf("v%0d_stall", i),  fetch_stall, 64'(tbl[i].e_stall));
      check($sformatf("v%0d_halted", i), halted,      64'(tbl[i].e_halted));
      check($sformatf("v%0d_dhalt", i),  dbg_halt,    64'(tbl[i].e_halted));
      check($sformatf("v%0d_ack", i),    req_ack,     64'(tbl[i].e_ack));
      check($sformatf("v%0d_cpc", i),    dbg_cpc,     64'(tbl[i].e_cpc));
      check($sformatf("v%0d_wrv", i),    dbg_wrv,     64'(tbl[i].e_wrv));
      check($sformatf("v%0d_err", i),    drain_err,   64'(tbl[i].e_err));
      if (tbl[i].e_cpc) check($sformatf("v%0d_pc", i), dbg_pc, CPC_ADDR);
      if (tbl[i].e_wrv) begin
        check($sformatf("v%0d_waddr", i), dbg_wr_addr, 64'(tbl[i].e_waddr));
        check($sformatf("v%0d_wdata", i), dbg_wr_data, tbl[i].e_wdata);
      end
      to_next();
    end
    idle_inputs();

    // Drain timeout with a never-empty pipeline.
    empty = 0; halt_req = 1; cycle();
    halt_req = 0;
    drained = 0;
    for (int i = 0; i < 20; i++) begin
      at_neg();
      if (halted) break;
      if (fetch_stall) drained++;
      to_next();
    end
    check("drain_halted", halted, 1);
    check("drain_cycles", drained, DT);
    check("drain_err_set", drain_err, 1);
    to_next();
    resume_req = 1; at_neg(); check("resume_ack", req_ack, 1); to_next();
    resume_req = 0; at_neg(); check("resume_err_clr", drain_err, 0);
    check("resume_stall", fetch_stall, 0); to_next();

    // Pipeline empties exactly in the timeout cycle: no error.
    halt_req = 1; cycle();
    halt_req = 0;
    repeat (DT - 1) cycle();
    empty = 1; cycle();
    at_neg(); check("empty_at_to_halted", halted, 1); check("empty_at_to_err", drain_err, 0);
    to_next();

    // Single step: fetch once, commit, drain, re-halt.
    step_req = 1; at_neg(); check("step_ack", req_ack, 1); to_next();
    step_req = 0; at_neg(); check("step_stall0", fetch_stall, 0); check("step_dhalt0", dbg_halt, 0); to_next();
    fire = 1; at_neg(); check("step_fire_stall", fetch_stall, 0); to_next();
    fire = 0; at_neg(); check("step_stall1", fetch_stall, 1); to_next();
    commit = 1; cycle();
    commit = 0; empty = 0; at_neg();
    check("step_drain_stall", fetch_stall, 1); check("step_drain_halted", halted, 0); to_next();
    empty = 1; cycle();
    at_neg(); check("step_rehalted", halted, 1); to_next();

    // Commit in the step-timeout cycle wins: no error.
    step_req = 1; cycle();
    step_req = 0;
    repeat (DT - 1) cycle();
    commit = 1; cycle();
    commit = 0; at_neg(); check("commit_vs_to_err", drain_err, 0); to_next();
    at_neg(); check("commit_vs_to_halted", halted, 1); to_next();

    // Pure step timeout sets the error.
    step_req = 1; cycle();
    step_req = 0;
    repeat (DT) cycle();
    at_neg(); check("step_to_err", drain_err, 1); check("step_to_drain", halted, 0); to_next();
    at_neg(); check("step_to_halted", halted, 1); to_next();
    resume_req = 1; cycle(); resume_req = 0;

    // Reset during STEPPING, with a change_pc pulse just issued.
    go_halted();
    cpc_req = 1; cycle(); cpc_req = 0;
    step_req = 1; cycle(); step_req = 0;
    rstn = 0; cycle();
    rstn = 1; at_neg();
    check("rst_stall", fetch_stall, 0); check("rst_dhalt", dbg_halt, 0);
    check("rst_halted", halted, 0);     check("rst_cpc", dbg_cpc, 0);
    check("rst_pc", dbg_pc, 0);         check("rst_wrv", dbg_wrv, 0);
    check("rst_err", drain_err, 0);     check("rst_ack", req_ack, 0);
    to_next();

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rstn       = ($urandom_range(255) != 0);
      halt_req   = ($urandom_range(7) == 0);
      resume_req = ($urandom_range(5) == 0);
      step_req   = ($urandom_range(7) == 0);
      cpc_req    = ($urandom_range(9) == 0);
      wr_req     = ($urandom_range(7) == 0);
      cpc_addr   = {$urandom, $urandom};
      wr_addr    = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      wr_data    = {$urandom, $urandom};
      empty      = ($urandom_range(2) != 0);
      fire       = ($urandom_range(3) == 0);
      commit     = ($urandom_range(9) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
